// File: rtl/booth_dot_acc_if.sv
// Stream interface for booth_dot_acc: product input, result output and abort control.
// The master side feeds products and consumes results; the slave side is the accumulator.
interface booth_dot_acc_if #(
  parameter int ACC_W = 12
) ();
  logic             clr;
  logic [7:0]       prod;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output clr, prod, in_valid, out_ready,
    input  in_ready, acc_out, sat, out_valid, busy
  );

  modport slave (
    input  clr, prod, in_valid, out_ready,
    output in_ready, acc_out, sat, out_valid, busy
  );
endinterface

// File: rtl/booth_dot_acc.sv
// Saturating dot-product accumulator: sums TERMS signed 8-bit products and
// holds the clamped result on a valid/ready port until the consumer takes it.
module booth_dot_acc #(
  parameter int TERMS = 4,
  parameter int ACC_W = 12
) (
  input logic            clk,
  input logic            rst_n,
  booth_dot_acc_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic [4:0]            LAST_CNT = 5'(TERMS - 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    sat_out_q, sat_out_d;
  logic                    out_valid_q, out_valid_d;

  logic                    in_ready;
  logic                    busy;
  logic                    in_hs;
  logic                    sat_next;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W:0]   clamped;

  // One guard bit is enough: |acc| + |prod| never exceeds 2^ACC_W.
  always_comb begin
    sum      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){bus.prod[7]}}, bus.prod};
    clamped  = sum;
    sat_next = sat_q;
    if (sum > SUM_MAX) begin
      clamped  = SUM_MAX;
      sat_next = 1'b1;
    end else if (sum < SUM_MIN) begin
      clamped  = SUM_MIN;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    in_hs       = bus.in_valid & in_ready;
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    acc_out_d   = acc_out_q;
    sat_out_d   = sat_out_q;
    out_valid_d = out_valid_q;
    if (bus.clr) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_hs && cnt_q == LAST_CNT) begin
            acc_out_d   = clamped[ACC_W-1:0];
            sat_out_d   = sat_next;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            state_d     = HOLD;
          end else if (in_hs) begin
            acc_d = clamped[ACC_W-1:0];
            cnt_d = cnt_q + 5'd1;
            sat_d = sat_next;
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      acc_out_q   <= '0;
      sat_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      acc_out_q   <= acc_out_d;
      sat_out_q   <= sat_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready decodes state only, so it never loops back through in_valid or out_ready.
  always_comb begin
    in_ready = (state_q == ACCUM);
    busy     = (cnt_q != 5'd0) | out_valid_q;
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.acc_out   = acc_out_q;
  assign bus.sat       = sat_out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_booth_dot_acc.sv
// Directed bench for booth_dot_acc; drives a 12-bit and an 8-bit accumulator
// with identical streams so the 8-bit copy exercises the saturation rails.
module tb_booth_dot_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] prod = 8'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  int         checks = 0;
  int         passed = 0;

  booth_dot_acc_if #(.ACC_W(12)) b12 ();
  booth_dot_acc_if #(.ACC_W(8))  b8 ();

  assign b12.clr = clr;
  assign b12.prod = prod;
  assign b12.in_valid = in_valid;
  assign b12.out_ready = out_ready;
  assign b8.clr = clr;
  assign b8.prod = prod;
  assign b8.in_valid = in_valid;
  assign b8.out_ready = out_ready;

  booth_dot_acc #(.TERMS(4), .ACC_W(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));
  booth_dot_acc #(.TERMS(4), .ACC_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  always #5 clk = ~clk;

  // Inputs change just after a falling edge and outputs are read there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (b12.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", b12.in_ready); else passed++;
    checks++; if (b12.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", b12.out_valid); else passed++;
    checks++; if (b12.acc_out !== 12'd0) $display("[TB] FAIL reset_acc_out: got %0d expected 0", $signed(b12.acc_out)); else passed++;
    checks++; if (b12.sat !== 1'b0) $display("[TB] FAIL reset_sat: got %b expected 0", b12.sat); else passed++;
    checks++; if (b12.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", b12.busy); else passed++;
    checks++; if (b8.acc_out !== 8'd0) $display("[TB] FAIL reset_acc_out8: got %0d expected 0", $signed(b8.acc_out)); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sum();
    int p [4] = '{10, -3, 64, -56};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(p[i]);
      in_valid = 1'b1;
      step();
      if (i < 3) begin
        checks++; if (b12.busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1", b12.busy); else passed++;
        checks++; if (b12.out_valid !== 1'b0) $display("[TB] FAIL basic_early_valid: got %b expected 0", b12.out_valid); else passed++;
      end
    end
    checks++; if (b12.out_valid !== 1'b1) $display("[TB] FAIL basic_out_valid: got %b expected 1", b12.out_valid); else passed++;
    checks++; if (b12.acc_out !== 12'(15)) $display("[TB] FAIL basic_acc12: got %0d expected 15", $signed(b12.acc_out)); else passed++;
    checks++; if (b12.sat !== 1'b0) $display("[TB] FAIL basic_sat: got %b expected 0", b12.sat); else passed++;
    checks++; if (b12.in_ready !== 1'b0) $display("[TB] FAIL basic_hold_ready: got %b expected 0", b12.in_ready); else passed++;
    checks++; if (b8.acc_out !== 8'(15)) $display("[TB] FAIL basic_acc8: got %0d expected 15", $signed(b8.acc_out)); else passed++;
    in_valid = 1'b0;
    step();
    checks++; if (b12.in_ready !== 1'b1) $display("[TB] FAIL basic_ready_back: got %b expected 1", b12.in_ready); else passed++;
    checks++; if (b12.out_valid !== 1'b0) $display("[TB] FAIL basic_valid_drop: got %b expected 0", b12.out_valid); else passed++;
    checks++; if (b12.acc_out !== 12'(15)) $display("[TB] FAIL basic_acc_held: got %0d expected 15", $signed(b12.acc_out)); else passed++;
    checks++; if (b12.busy !== 1'b0) $display("[TB] FAIL basic_idle_busy: got %b expected 0", b12.busy); else passed++;
  endtask

  task automatic test_saturation();
    int p [4] = '{64, 64, 64, -56};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(p[i]);
      in_valid = 1'b1;
      step();
    end
    checks++; if (b8.acc_out !== 8'(71)) $display("[TB] FAIL sat_pos_acc8: got %0d expected 71", $signed(b8.acc_out)); else passed++;
    checks++; if (b8.sat !== 1'b1) $display("[TB] FAIL sat_pos_flag8: got %b expected 1", b8.sat); else passed++;
    checks++; if (b12.acc_out !== 12'(136)) $display("[TB] FAIL sat_pos_acc12: got %0d expected 136", $signed(b12.acc_out)); else passed++;
    checks++; if (b12.sat !== 1'b0) $display("[TB] FAIL sat_pos_flag12: got %b expected 0", b12.sat); else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_negative_rail();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(-56);
      in_valid = 1'b1;
      step();
    end
    checks++; if (b8.acc_out !== 8'(-128)) $display("[TB] FAIL neg_rail_acc8: got %0d expected -128", $signed(b8.acc_out)); else passed++;
    checks++; if (b8.sat !== 1'b1) $display("[TB] FAIL neg_rail_flag8: got %b expected 1", b8.sat); else passed++;
    checks++; if (b12.acc_out !== 12'(-224)) $display("[TB] FAIL neg_rail_acc12: got %0d expected -224", $signed(b12.acc_out)); else passed++;
    checks++; if (b12.sat !== 1'b0) $display("[TB] FAIL neg_rail_flag12: got %b expected 0", b12.sat); else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_input_gaps();
    int p [4] = '{20, -5, 7, 1};
    int gap [4] = '{3, 1, 0, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(p[i]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      prod = 8'(99);
      for (int g = 0; g < gap[i]; g++) begin
        step();
        checks++; if (b12.busy !== 1'b1) $display("[TB] FAIL gap_busy: got %b expected 1", b12.busy); else passed++;
      end
    end
    checks++; if (b12.out_valid !== 1'b1) $display("[TB] FAIL gap_out_valid: got %b expected 1", b12.out_valid); else passed++;
    checks++; if (b12.acc_out !== 12'(23)) $display("[TB] FAIL gap_acc: got %0d expected 23", $signed(b12.acc_out)); else passed++;
    step();
  endtask

  task automatic test_backpressure();
    int p [4] = '{1, 2, 3, 4};
    int q [4] = '{5, 6, 7, 8};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(p[i]);
      in_valid = 1'b1;
      step();
    end
    prod = 8'(100);
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (b12.in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b expected 0", b12.in_ready); else passed++;
      checks++; if (b12.out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid: got %b expected 1", b12.out_valid); else passed++;
      checks++; if (b12.acc_out !== 12'(10)) $display("[TB] FAIL bp_acc_stable: got %0d expected 10", $signed(b12.acc_out)); else passed++;
    end
    out_ready = 1'b1;
    step();
    checks++; if (b12.out_valid !== 1'b0) $display("[TB] FAIL bp_release: got %b expected 0", b12.out_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(q[i]);
      step();
    end
    checks++; if (b12.acc_out !== 12'(26)) $display("[TB] FAIL bp_fresh_acc: got %0d expected 26", $signed(b12.acc_out)); else passed++;
    checks++; if (b8.acc_out !== 8'(26)) $display("[TB] FAIL bp_fresh_acc8: got %0d expected 26", $signed(b8.acc_out)); else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int p [2] = '{5, 7};
    int q [4] = '{1, 2, 3, 4};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prod = 8'(p[i]);
      in_valid = 1'b1;
      step();
    end
    clr = 1'b1;
    prod = 8'(99);
    step();
    clr = 1'b0;
    checks++; if (b12.busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", b12.busy); else passed++;
    checks++; if (b12.in_ready !== 1'b1) $display("[TB] FAIL abort_in_ready: got %b expected 1", b12.in_ready); else passed++;
    checks++; if (b12.acc_out !== 12'(26)) $display("[TB] FAIL abort_no_partial: got %0d expected 26", $signed(b12.acc_out)); else passed++;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(q[i]);
      step();
    end
    checks++; if (b12.out_valid !== 1'b1) $display("[TB] FAIL abort_out_valid: got %b expected 1", b12.out_valid); else passed++;
    checks++; if (b12.acc_out !== 12'(10)) $display("[TB] FAIL abort_acc: got %0d expected 10", $signed(b12.acc_out)); else passed++;
    checks++; if (b12.sat !== 1'b0) $display("[TB] FAIL abort_sat: got %b expected 0", b12.sat); else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_clr_with_handshake();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(1);
      in_valid = 1'b1;
      step();
    end
    checks++; if (b12.acc_out !== 12'(4)) $display("[TB] FAIL clrhs_acc: got %0d expected 4", $signed(b12.acc_out)); else passed++;
    in_valid = 1'b0;
    clr = 1'b1;
    out_ready = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (b12.out_valid !== 1'b0) $display("[TB] FAIL clrhs_out_valid: got %b expected 0", b12.out_valid); else passed++;
    checks++; if (b12.in_ready !== 1'b1) $display("[TB] FAIL clrhs_in_ready: got %b expected 1", b12.in_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    prod = 8'(3);
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if (b12.out_valid !== ((c % 5) == 4))
        $display("[TB] FAIL b2b_valid_c%0d: got %b expected %b", c, b12.out_valid, ((c % 5) == 4));
      else passed++;
      if ((c % 5) == 4) begin
        checks++; if (b12.acc_out !== 12'(12)) $display("[TB] FAIL b2b_acc_c%0d: got %0d expected 12", c, $signed(b12.acc_out)); else passed++;
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod = 8'(2);
      in_valid = 1'b1;
      step();
    end
    checks++; if (b12.out_valid !== 1'b1) $display("[TB] FAIL rsthold_pre_valid: got %b expected 1", b12.out_valid); else passed++;
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    checks++; if (b12.out_valid !== 1'b0) $display("[TB] FAIL rsthold_out_valid: got %b expected 0", b12.out_valid); else passed++;
    checks++; if (b12.acc_out !== 12'd0) $display("[TB] FAIL rsthold_acc_out: got %0d expected 0", $signed(b12.acc_out)); else passed++;
    checks++; if (b12.in_ready !== 1'b1) $display("[TB] FAIL rsthold_in_ready: got %b expected 1", b12.in_ready); else passed++;
    checks++; if (b12.busy !== 1'b0) $display("[TB] FAIL rsthold_busy: got %b expected 0", b12.busy); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_saturation();
    test_negative_rail();
    test_input_gaps();
    test_backpressure();
    test_abort();
    test_clr_with_handshake();
    test_back_to_back();
    test_reset_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
